// File: rtl/ins_loader.sv
// ins_loader: length-prefixed byte-stream loader driving the instruction-memory write port.
// Define INS_LOADER_CHECKSUM_EN to require a trailing XOR checksum byte after the payload.
`ifndef INS_START_ADDRESS
`define INS_START_ADDRESS 32'h0000_0000
`endif

module ins_loader #(
  parameter logic [31:0] START_ADDR = `INS_START_ADDRESS,
  parameter int unsigned MEM_BYTES  = 1000
) (
  input  logic        SYS_clk,
  input  logic        SYS_reset,
  input  logic        start,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        rx_ready,
  output logic        PC_to_mem_enable,
  output logic [7:0]  PC_to_mem_data,
  output logic [31:0] PC_to_mem_address,
  output logic        cpu_hold,
  output logic        load_done,
  output logic        load_error
);

  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] LEN  = 3'd1;
  localparam logic [2:0] LOAD = 3'd2;
  localparam logic [2:0] DONE = 3'd4;
  localparam logic [2:0] ERR  = 3'd5;
`ifdef INS_LOADER_CHECKSUM_EN
  localparam logic [2:0] CHK  = 3'd3;
  localparam logic [2:0] AFTER_PAYLOAD = CHK;
`else
  localparam logic [2:0] AFTER_PAYLOAD = DONE;
`endif

  localparam logic [31:0] MEM_LIMIT = 32'(MEM_BYTES);

  logic [2:0]  state_q, state_d;
  logic [31:0] len_q, len_d;
  logic [31:0] cnt_q, cnt_d;
  logic [31:0] addr_q, addr_d;
  logic [7:0]  data_q, data_d;
  logic        we_q, we_d;
`ifdef INS_LOADER_CHECKSUM_EN
  logic [7:0]  csum_q, csum_d;
`endif

  logic        xfer;
  logic [31:0] len_full;

`ifdef INS_LOADER_CHECKSUM_EN
  assign rx_ready = (state_q == LEN) || (state_q == LOAD) || (state_q == CHK);
`else
  assign rx_ready = (state_q == LEN) || (state_q == LOAD);
`endif

  assign xfer     = rx_valid && rx_ready;
  // Big-endian: the byte arriving now lands in the low byte, earlier bytes shift up.
  assign len_full = {len_q[23:0], rx_data};

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    data_d  = data_q;
    we_d    = 1'b0;
`ifdef INS_LOADER_CHECKSUM_EN
    csum_d  = csum_q;
`endif
    case (state_q)
      IDLE, DONE, ERR: begin
        if (start) begin
          state_d = LEN;
          cnt_d   = 32'd0;
          len_d   = 32'd0;
`ifdef INS_LOADER_CHECKSUM_EN
          csum_d  = 8'h00;
`endif
        end
      end
      LEN: begin
        if (xfer) begin
          len_d = len_full;
          if (cnt_q == 32'd3) begin
            cnt_d = 32'd0;
            if (len_full > MEM_LIMIT) begin
              state_d = ERR;
            end else if (len_full == 32'd0) begin
              state_d = AFTER_PAYLOAD;
            end else begin
              state_d = LOAD;
            end
          end else begin
            cnt_d = cnt_q + 32'd1;
          end
        end
      end
      LOAD: begin
        if (xfer) begin
          we_d   = 1'b1;
          data_d = rx_data;
          addr_d = START_ADDR + cnt_q;
          cnt_d  = cnt_q + 32'd1;
`ifdef INS_LOADER_CHECKSUM_EN
          csum_d = csum_q ^ rx_data;
`endif
          if (cnt_q == len_q - 32'd1) begin
            state_d = AFTER_PAYLOAD;
          end
        end
      end
`ifdef INS_LOADER_CHECKSUM_EN
      CHK: begin
        if (xfer) begin
          state_d = (rx_data == csum_q) ? DONE : ERR;
        end
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge SYS_clk or posedge SYS_reset) begin
    if (SYS_reset) begin
      state_q <= IDLE;
      len_q   <= 32'd0;
      cnt_q   <= 32'd0;
      addr_q  <= START_ADDR;
      data_q  <= 8'h00;
      we_q    <= 1'b0;
`ifdef INS_LOADER_CHECKSUM_EN
      csum_q  <= 8'h00;
`endif
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      we_q    <= we_d;
`ifdef INS_LOADER_CHECKSUM_EN
      csum_q  <= csum_d;
`endif
    end
  end

  assign PC_to_mem_enable  = we_q;
  assign PC_to_mem_data    = data_q;
  assign PC_to_mem_address = addr_q;
  assign cpu_hold          = (state_q != DONE);
  assign load_done         = (state_q == DONE);
  assign load_error        = (state_q == ERR);

endmodule

// File: tb/tb_ins_loader.sv
// Self-checking bench for ins_loader: table-driven images, hand-written corner sequences,
// and randomized images scored against a stream-level reference model.
module tb_ins_loader;

  localparam logic [31:0] START = 32'h0000_0100;
  localparam int          MEMB  = 1000;
`ifdef INS_LOADER_CHECKSUM_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic        SYS_clk = 1'b0;
  logic        SYS_reset = 1'b1;
  logic        start = 1'b0;
  logic        rx_valid = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_ready;
  logic        PC_to_mem_enable;
  logic [7:0]  PC_to_mem_data;
  logic [31:0] PC_to_mem_address;
  logic        cpu_hold;
  logic        load_done;
  logic        load_error;

  ins_loader #(.START_ADDR(START), .MEM_BYTES(MEMB)) dut (
    .SYS_clk(SYS_clk),
    .SYS_reset(SYS_reset),
    .start(start),
    .rx_valid(rx_valid),
    .rx_data(rx_data),
    .rx_ready(rx_ready),
    .PC_to_mem_enable(PC_to_mem_enable),
    .PC_to_mem_data(PC_to_mem_data),
    .PC_to_mem_address(PC_to_mem_address),
    .cpu_hold(cpu_hold),
    .load_done(load_done),
    .load_error(load_error)
  );

  always #5 SYS_clk = ~SYS_clk;

  int total = 0;
  int bad   = 0;

  logic [39:0] got_q[$];
  logic [39:0] exp_q[$];
  logic [7:0]  stream_q[$];
  logic [7:0]  pay_q[$];
  bit          exp_done;
  bit          exp_err;

  typedef struct {
    logic [31:0] len;
    int          gapMode;
    bit          corrupt;
    bit          expDone;
    bit          expErr;
  } vec_t;

  vec_t vecs[7];

  // Every strobe seen mid-cycle is one memory write {address, data}.
  always @(negedge SYS_clk) begin
    if (!SYS_reset && PC_to_mem_enable) got_q.push_back({PC_to_mem_address, PC_to_mem_data});
  end

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  // Reference model: builds the byte stream, the expected writes and the final verdict.
  task automatic modelImage(input logic [31:0] len, input bit corrupt);
    logic [7:0] x;
    x = 8'h00;
    stream_q.delete();
    exp_q.delete();
    for (int i = 0; i < 4; i++) stream_q.push_back(len[31 - 8*i -: 8]);
    if (len > MEMB) begin
      exp_done = 1'b0;
      exp_err  = 1'b1;
      return;
    end
    for (int k = 0; k < int'(len); k++) begin
      stream_q.push_back(pay_q[k]);
      exp_q.push_back({32'(START + 32'(k)), pay_q[k]});
      x = x ^ pay_q[k];
    end
    exp_done = 1'b1;
    exp_err  = 1'b0;
    if (CHK) begin
      stream_q.push_back(corrupt ? ~x : x);
      if (corrupt) begin
        exp_done = 1'b0;
        exp_err  = 1'b1;
      end
    end
  endtask

  task automatic randomPayload(input logic [31:0] len);
    pay_q.delete();
    if (len <= MEMB) begin
      for (int k = 0; k < int'(len); k++) pay_q.push_back(8'($urandom));
    end
  endtask

  task automatic pulseStart();
    @(negedge SYS_clk);
    start = 1'b1;
    @(negedge SYS_clk);
    start = 1'b0;
  endtask

  // Called at a negedge; returns at the negedge after the byte transferred.
  task automatic sendByte(input logic [7:0] b);
    int waitc;
    waitc = 0;
    rx_valid = 1'b1;
    rx_data  = b;
    while (!rx_ready && waitc < 20) begin
      @(negedge SYS_clk);
      waitc++;
    end
    checkOutput("rx_ready_wait", rx_ready, 1);
    @(negedge SYS_clk);
    rx_valid = 1'b0;
  endtask

  task automatic sendFrom(input int first, input int last, input int gapMode);
    for (int i = first; i <= last; i++) begin
      if ((gapMode == 1 && i > first) || (gapMode == 2 && $urandom_range(1) == 1)) @(negedge SYS_clk);
      sendByte(stream_q[i]);
    end
  endtask

  task automatic applyStimulus(input int gapMode);
    pulseStart();
    sendFrom(0, stream_q.size() - 1, gapMode);
    repeat (3) @(negedge SYS_clk);
  endtask

  task automatic checkImage(input string tag);
    checkOutput({tag, "_nwrites"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      checkOutput({tag, "_write"}, got_q[i], exp_q[i]);
    checkOutput({tag, "_done"}, load_done, exp_done);
    checkOutput({tag, "_error"}, load_error, exp_err);
    checkOutput({tag, "_hold"}, cpu_hold, !exp_done);
    checkOutput({tag, "_rx_ready"}, rx_ready, 0);
    checkOutput({tag, "_strobe_idle"}, PC_to_mem_enable, 0);
    got_q.delete();
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_rx_ready"}, rx_ready, 0);
    checkOutput({tag, "_strobe"}, PC_to_mem_enable, 0);
    checkOutput({tag, "_data"}, PC_to_mem_data, 0);
    checkOutput({tag, "_addr"}, PC_to_mem_address, START);
    checkOutput({tag, "_hold"}, cpu_hold, 1);
    checkOutput({tag, "_done"}, load_done, 0);
    checkOutput({tag, "_error"}, load_error, 0);
  endtask

  initial begin
    vecs[0] = '{len: 32'd4,          gapMode: 0, corrupt: 1'b0, expDone: 1'b1, expErr: 1'b0};
    vecs[1] = '{len: 32'd0,          gapMode: 0, corrupt: 1'b0, expDone: 1'b1, expErr: 1'b0};
    vecs[2] = '{len: 32'h0000_03E9,  gapMode: 0, corrupt: 1'b0, expDone: 1'b0, expErr: 1'b1};
    vecs[3] = '{len: 32'd1000,       gapMode: 0, corrupt: 1'b0, expDone: 1'b1, expErr: 1'b0};
    vecs[4] = '{len: 32'h0100_0000,  gapMode: 0, corrupt: 1'b0, expDone: 1'b0, expErr: 1'b1};
    vecs[5] = '{len: 32'd7,          gapMode: 1, corrupt: 1'b0, expDone: 1'b1, expErr: 1'b0};
    vecs[6] = '{len: 32'd3,          gapMode: 2, corrupt: 1'b1, expDone: !CHK, expErr: CHK};

    // Reset and idle.
    #12;
    checkResetValues("reset");
    @(negedge SYS_clk);
    SYS_reset = 1'b0;
    repeat (10) begin
      @(negedge SYS_clk);
      checkOutput("idle_strobe", PC_to_mem_enable, 0);
      checkOutput("idle_hold", cpu_hold, 1);
      checkOutput("idle_rx_ready", rx_ready, 0);
      checkOutput("idle_flags", {load_done, load_error}, 0);
    end

    // Basic load: release must coincide with the final payload strobe (no-checksum build).
    pay_q = {8'h13, 8'h05, 8'h10, 8'h00};
    modelImage(32'd4, 1'b0);
    pulseStart();
    sendFrom(0, stream_q.size() - 1, 0);
    checkOutput("basic_last_strobe", PC_to_mem_enable, !CHK);
    checkOutput("basic_done_edge", load_done, 1);
    checkOutput("basic_hold_edge", cpu_hold, 0);
    repeat (3) @(negedge SYS_clk);
    checkImage("basic");

    // Table-driven images.
    for (int v = 0; v < 7; v++) begin
      if (v == 0) pay_q = {8'h13, 8'h05, 8'h10, 8'h00};
      else randomPayload(vecs[v].len);
      modelImage(vecs[v].len, vecs[v].corrupt);
      exp_done = vecs[v].expDone;
      exp_err  = vecs[v].expErr;
      applyStimulus(vecs[v].gapMode);
      checkImage($sformatf("tbl%0d", v));
    end

    // Start pulses during LEN and LOAD are ignored.
    pay_q = {8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h01, 8'h02};
    modelImage(32'd6, 1'b0);
    pulseStart();
    start = 1'b1;
    sendFrom(0, 1, 0);
    start = 1'b0;
    sendFrom(2, 5, 0);
    start = 1'b1;
    sendFrom(6, 6, 0);
    start = 1'b0;
    sendFrom(7, stream_q.size() - 1, 0);
    repeat (3) @(negedge SYS_clk);
    checkImage("start_ignored");

    // Reset mid-load after two payload bytes, then a fresh full load.
    pay_q = {8'h13, 8'h05, 8'h10, 8'h00};
    modelImage(32'd4, 1'b0);
    pulseStart();
    sendFrom(0, 5, 0);
    #2 SYS_reset = 1'b1;
    #1 checkResetValues("midreset");
    @(negedge SYS_clk);
    SYS_reset = 1'b0;
    got_q.delete();
    applyStimulus(0);
    checkImage("after_reset");

`ifdef INS_LOADER_CHECKSUM_EN
    pay_q = {8'hAA, 8'h55};
    modelImage(32'd2, 1'b0);
    stream_q[6] = 8'hFE;
    exp_done = 1'b0;
    exp_err  = 1'b1;
    applyStimulus(0);
    checkImage("chk_bad");
    modelImage(32'd2, 1'b0);
    stream_q[6] = 8'hFF;
    applyStimulus(0);
    checkImage("chk_good");
`endif

    // Randomized images against the reference model.
    for (int r = 0; r < 25; r++) begin
      logic [31:0] len;
      len = ($urandom_range(7) == 0) ? 32'(MEMB + 1 + $urandom_range(50)) : 32'($urandom_range(40));
      randomPayload(len);
      modelImage(len, 1'($urandom_range(1)));
      applyStimulus(int'($urandom_range(2)));
      checkImage($sformatf("rand%0d", r));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL timeout: got running expected finished");
    $fatal(1, "[TB] simulation time limit");
  end

endmodule

// File: doc/ins_loader.md
# ins_loader

Byte-stream program loader that sits directly upstream of the instruction memory and drives its loader write port (`PC_to_mem_enable` / `PC_to_mem_data` / `PC_to_mem_address`). It accepts a length-prefixed byte stream from a receiver (e.g. UART RX) over a valid/ready handshake. It writes the payload bytes sequentially into instruction memory starting at the instruction base address, and holds the CPU until the image is complete.

## Interface

Parameters:
- `START_ADDR`, default `` `INS_START_ADDRESS ``: byte address of the first payload byte.
- `MEM_BYTES`, default 1000: instruction-memory capacity in bytes; the largest legal image length.

Ports:
- `SYS_clk`  in  1: system clock; all state updates on the rising edge.
- `SYS_reset`  in  1: reset, asynchronous and active-high.
- `start`  in  1: one-cycle pulse that begins a load; honoured only in IDLE, DONE or ERR.
- `rx_valid`  in  1: `rx_data` holds a byte.
- `rx_data`  in  8: incoming stream byte.
- `rx_ready`  out  1: loader can accept a byte this cycle.
- `PC_to_mem_enable`  out  1: instruction-memory byte write strobe.
- `PC_to_mem_data`  out  8: byte to write.
- `PC_to_mem_address`  out  32: byte address to write.
- `cpu_hold`  out  1: keep CPU/PC stalled; high until a good image is loaded.
- `load_done`  out  1: level; image loaded successfully.
- `load_error`  out  1: level; load aborted.

## Operation

- States: IDLE, LEN, LOAD, CHK (only with checksum, see Configuration), DONE, ERR.
- Transfer rule: a byte transfers when `rx_valid & rx_ready` at a rising edge.
- `rx_ready` = 1 in LEN, LOAD and CHK; 0 in all other states.
- IDLE: on `start`, clear the byte counter, length register and checksum; go to LEN.
- LEN: collect 4 transferred bytes as a 32-bit length L, big-endian (first byte becomes L[31:24]). On the 4th byte:
  - L > `MEM_BYTES`: go to ERR.
  - L == 0: go to CHK if enabled, else DONE.
  - Otherwise go to LOAD.
- LOAD: each transferred byte k (k = 0..L-1) is written to `START_ADDR + k`. After byte L-1, go to CHK if enabled, else DONE.
- DONE: `load_done`=1, `cpu_hold`=0. A new `start` restarts the load: DONE→LEN with `cpu_hold`=1 and `load_done`=0.
- ERR: `load_error`=1, `cpu_hold` stays 1, no further memory writes. A new `start` clears `load_error` and goes to LEN.
- `start` pulses in LEN, LOAD or CHK are ignored.
- The address never wraps: the L ≤ `MEM_BYTES` check guarantees the last address is `START_ADDR + MEM_BYTES - 1`.
- Length bytes and checksum bytes are never written to memory.

## Timing

- Reset values: state IDLE, `rx_ready`=0, `PC_to_mem_enable`=0, `PC_to_mem_data`=0, `PC_to_mem_address`=`START_ADDR`, `cpu_hold`=1, `load_done`=0, `load_error`=0.
- Reset asserted mid-load aborts immediately: all outputs return to reset values and the partial image is abandoned.
- Write latency: payload byte transferred at edge N gives `PC_to_mem_enable`=1 for exactly the cycle after edge N. Address and data are registered and stable during that cycle.
- Back-to-back transfers produce consecutive single-cycle strobes with incrementing addresses, sustaining 1 byte/cycle.
- Gaps in `rx_valid` insert idle cycles, with strobe 0 during the gaps.
- `cpu_hold` falls, and `load_done` rises, at the same edge that enters DONE. That edge is also the one at which the final payload write strobe is asserted, so the CPU is released no earlier than the last write.
- `load_error` rises on the edge that enters ERR.

## Configuration

- Macro: `INS_LOADER_CHECKSUM_EN`.
- Defined:
  - After the payload (or immediately after LEN when L=0), state CHK accepts one byte C.
  - C must equal the XOR of all L payload bytes, with XOR of zero bytes = 0x00.
  - Match: go to DONE. Mismatch: go to ERR.
  - `cpu_hold` stays 1 through CHK.
- Undefined: CHK state and checksum logic are absent; LOAD (or L=0 in LEN) goes directly to DONE.

## Test plan

- Reset and idle: release reset and hold `start`=0 for 10 cycles → `cpu_hold`=1, `rx_ready`=0, no write strobes, `load_done`=`load_error`=0.
- Basic load: `start`, then stream 00 00 00 04, 13 05 10 00 back-to-back (plus checksum 06 if enabled) → 4 strobes at `START_ADDR`..+3 with data 13,05,10,00 → `load_done`=1, `cpu_hold`=0.
- Oversize: L = 0x000003E9 (1001) → ERR after the 4th length byte, `load_error`=1, no strobes, `rx_ready`=0.
- Stalled source: same 4-byte image with `rx_valid` low every other cycle → same 4 writes, each strobe exactly one cycle, addresses contiguous.
- Reset mid-load: assert `SYS_reset` after 2 payload bytes → outputs return to reset values asynchronously; a fresh `start` plus full stream loads correctly.
- Checksum (macro defined): stream 00 00 00 02, AA 55, then FE → ERR with `cpu_hold`=1. Repeat with checksum FF → DONE.
